// File: rtl/fp_sched_pkg.sv
// Shared definitions for the floating-point unit scheduler: opcodes, FSM
// state encoding and default datapath widths.
package fp_sched_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int MUL_W_DEF  = 56;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant. The pointer names the requester that wins a tie
// and moves to the other requester only when a grant is actually accepted.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  input  logic       accept,
  output logic [1:0] grant
);

  // 0 favours requester 0, 1 favours requester 1
  logic ptr;

  // combinational one-hot grant, suppressed when the scheduler is not idle
  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req[0] && (!req[1] || !ptr)) begin
        grant = 2'b01;
      end else if (req[1]) begin
        grant = 2'b10;
      end
    end
  end

  // pointer hands priority to the requester that did not just win
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (accept) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/fp_unit_scheduler.sv
// Shares one combinational float add/sub + mul datapath between two
// requesters. Operands are registered onto the datapath, allowed LAT cycles to
// settle, and the captured result is returned with the issuing requester id.
//
// state | meaning
// IDLE  | arbitrating; winner's ready is high, handshake loads the datapath
// EXEC  | datapath settling; result captured when the settle counter hits 0
// RESP  | response held on rsp_* until the consumer accepts it
module fp_unit_scheduler
  import fp_sched_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int MUL_W  = MUL_W_DEF,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [1:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [1:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [DATA_W-1:0] dp_a,
  output logic [DATA_W-1:0] dp_b,
  output logic              dp_add_sub,
  input  logic [DATA_W-1:0] dp_addsub_res,
  input  logic [MUL_W-1:0]  dp_mul_res,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic              rsp_err,
  output logic [MUL_W-1:0]  rsp_data
);

  state_t     state;
  logic [3:0] cnt;
  logic [1:0] op_q;
  logic       id_q;
  logic [1:0] grant;
  logic       accept;
  logic       win1;
  logic [1:0] win_op;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({req1_valid, req0_valid}),
    .en     ((state == IDLE) && !rst),
    .accept (accept),
    .grant  (grant)
  );

  // a grant is only issued to a valid requester, so grant doubles as handshake
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign accept     = |grant;
  assign win1       = grant[1];
  assign win_op     = win1 ? req1_op : req0_op;

  // sequencing FSM with registered datapath and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      op_q       <= OP_ADD;
      id_q       <= 1'b0;
      dp_a       <= '0;
      dp_b       <= '0;
      dp_add_sub <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dp_a       <= win1 ? req1_a : req0_a;
            dp_b       <= win1 ? req1_b : req0_b;
            dp_add_sub <= (win_op == OP_ADD);
            op_q       <= win_op;
            id_q       <= win1;
            cnt        <= 4'(LAT - 1);
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_valid <= 1'b1;
            rsp_id    <= id_q;
            case (op_q)
              OP_MUL: begin
                rsp_data <= dp_mul_res;
                rsp_err  <= 1'b0;
              end
              OP_RSV: begin
                rsp_data <= '0;
                rsp_err  <= 1'b1;
              end
              default: begin
                rsp_data <= {{(MUL_W - DATA_W){1'b0}}, dp_addsub_res};
                rsp_err  <= 1'b0;
              end
            endcase
            state <= RESP;
          end
        end
        RESP: begin
          // returning to IDLE first keeps a new accept out of the handshake cycle
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_unit_scheduler.sv
// Directed bench for fp_unit_scheduler with LAT=2. Inputs change just after the
// rising edge or on the falling edge; outputs are checked on the falling edge.
module tb_fp_unit_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [1:0]  req0_op = 2'b00, req1_op = 2'b00;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [31:0] dp_a, dp_b;
  logic        dp_add_sub;
  logic [31:0] dp_addsub_res = '0;
  logic [55:0] dp_mul_res = '0;
  logic        rsp_valid, rsp_id, rsp_err;
  logic        rsp_ready = 1'b0;
  logic [55:0] rsp_data;

  int checks = 0;
  int failures = 0;

  fp_unit_scheduler #(.DATA_W(32), .MUL_W(56), .LAT(2)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .dp_a(dp_a), .dp_b(dp_b), .dp_add_sub(dp_add_sub),
    .dp_addsub_res(dp_addsub_res), .dp_mul_res(dp_mul_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_err(rsp_err), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset state, ready held low while rst is high
    tick();
    req0_valid = 1'b1;
    req0_op = 2'b00; req0_a = 32'h3F800000; req0_b = 32'h40000000;
    dp_addsub_res = 32'h40400000;
    dp_mul_res = 56'h00ABCDEF012345;
    @(negedge clk);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_dp_a", dp_a, 0);
    chk("rst_dp_b", dp_b, 0);
    chk("rst_add_sub", dp_add_sub, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_data", rsp_data, 0);

    // 1: req0 add, response at T+3
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("t1_ready0", req0_ready, 1);
    chk("t1_ready1", req1_ready, 0);
    tick(); req0_valid = 1'b0;
    @(negedge clk);
    chk("t1_dp_a", dp_a, 64'h3F800000);
    chk("t1_dp_b", dp_b, 64'h40000000);
    chk("t1_add_sub", dp_add_sub, 1);
    chk("t1_valid_t1", rsp_valid, 0);
    tick();
    @(negedge clk);
    chk("t1_valid_t2", rsp_valid, 0);
    tick();
    @(negedge clk);
    chk("t1_valid_t3", rsp_valid, 1);
    chk("t1_id", rsp_id, 0);
    chk("t1_err", rsp_err, 0);
    chk("t1_data", rsp_data, 64'h40400000);
    rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("t1_valid_done", rsp_valid, 0);
    rsp_ready = 1'b0;

    // 2: simultaneous requests after reset, req0 first
    rst = 1'b1;
    tick(); rst = 1'b0;
    dp_addsub_res = 32'h0BADF00D;
    req0_valid = 1'b1; req0_op = 2'b10; req0_a = 32'h11111111; req0_b = 32'h22222222;
    req1_valid = 1'b1; req1_op = 2'b01; req1_a = 32'h33333333; req1_b = 32'h44444444;
    @(negedge clk);
    chk("t2_ready0", req0_ready, 1);
    chk("t2_ready1", req1_ready, 0);
    tick(); req0_valid = 1'b0;
    @(negedge clk);
    chk("t2_dp_a0", dp_a, 64'h11111111);
    chk("t2_add_sub0", dp_add_sub, 0);
    chk("t2_ready1_exec", req1_ready, 0);
    tick(); tick();
    @(negedge clk);
    chk("t2_valid0", rsp_valid, 1);
    chk("t2_data0", rsp_data, 64'h00ABCDEF012345);
    chk("t2_id0", rsp_id, 0);
    chk("t2_ready1_resp", req1_ready, 0);
    rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("t2_valid_done", rsp_valid, 0);
    chk("t2_ready1_idle", req1_ready, 1);
    rsp_ready = 1'b0;
    tick(); req1_valid = 1'b0;
    @(negedge clk);
    chk("t2_dp_a1", dp_a, 64'h33333333);
    chk("t2_dp_b1", dp_b, 64'h44444444);
    chk("t2_add_sub1", dp_add_sub, 0);
    tick(); tick();
    @(negedge clk);
    chk("t2_valid1", rsp_valid, 1);
    chk("t2_id1", rsp_id, 1);
    chk("t2_data1", rsp_data, 64'h0BADF00D);

    // 3: back-pressure holds everything, no grants
    req0_valid = 1'b1; req0_op = 2'b00; req0_a = 32'h55555555;
    req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      chk("t3_valid", rsp_valid, 1);
      chk("t3_data", rsp_data, 64'h0BADF00D);
      chk("t3_dp_a", dp_a, 64'h33333333);
      chk("t3_ready0", req0_ready, 0);
      chk("t3_ready1", req1_ready, 0);
    end
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("t3_valid_done", rsp_valid, 0);
    chk("t3_ready0_idle", req0_ready, 1);
    req0_valid = 1'b0;
    rsp_ready = 1'b0;

    // 4: reserved opcode from req1
    tick();
    req1_valid = 1'b1; req1_op = 2'b11; req1_a = 32'h66666666;
    @(negedge clk);
    chk("t4_ready1", req1_ready, 1);
    tick(); req1_valid = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("t4_valid", rsp_valid, 1);
    chk("t4_err", rsp_err, 1);
    chk("t4_data", rsp_data, 0);
    chk("t4_id", rsp_id, 1);
    rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("t4_err_clr", rsp_err, 0);
    chk("t4_valid_done", rsp_valid, 0);
    rsp_ready = 1'b0;

    // 5: reset during EXEC abandons the op and restores the pointer
    tick();
    req0_valid = 1'b1; req0_op = 2'b01; req0_a = 32'h77777777;
    @(negedge clk);
    chk("t5_ready0", req0_ready, 1);
    tick(); req0_valid = 1'b0;
    @(negedge clk);
    chk("t5_dp_a_exec", dp_a, 64'h77777777);
    rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("t5_valid_rst", rsp_valid, 0);
    chk("t5_dp_a_rst", dp_a, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      chk("t5_no_stale", rsp_valid, 0);
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("t5_ptr_ready0", req0_ready, 1);
    chk("t5_ptr_ready1", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // 6: req1 streams three ops, then a contended grant
    tick();
    req1_valid = 1'b1; req1_op = 2'b00; rsp_ready = 1'b1;
    req0_op = 2'b10; req0_a = 32'h0A0A0A0A;
    for (int k = 0; k < 3; k++) begin
      req1_a = 32'h10000000 + 32'(k);
      @(negedge clk);
      chk("t6_ready1", req1_ready, 1);
      chk("t6_ready0", req0_ready, 0);
      tick();
      @(negedge clk);
      chk("t6_dp_a", dp_a, 64'h10000000 + 64'(k));
      tick(); tick();
      @(negedge clk);
      chk("t6_valid", rsp_valid, 1);
      chk("t6_id", rsp_id, 1);
      if (k == 2) req0_valid = 1'b1;
      tick();
    end
    @(negedge clk);
    chk("t6_contend_ready0", req0_ready, 1);
    chk("t6_contend_ready1", req1_ready, 0);
    tick(); req0_valid = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("t6_r0_valid", rsp_valid, 1);
    chk("t6_r0_id", rsp_id, 0);
    chk("t6_r0_data", rsp_data, 64'h00ABCDEF012345);
    tick();
    @(negedge clk);
    chk("t6_next_ready1", req1_ready, 1);
    req1_valid = 1'b0;
    rsp_ready = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
